// File: rtl/shiftreg_sequencer.sv
// Command sequencer for the 4-bit enhanced shift register. It accepts one op over valid/ready,
// drives the register for the required cycles, then reports Q and the serial bits shifted out.
`timescale 1ns/1ps
module shiftreg_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enb,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    input  logic [CNT_W-1:0] i_cmd_count,
    output logic             o_reg_enb,
    output logic [1:0]       o_modo,
    output logic             o_dir,
    output logic             o_s_in,
    output logic [WIDTH-1:0] o_d,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_s_out,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_out_bits,
    output logic             o_done,
    output logic             o_err
);

    localparam logic [2:0] OpLoad  = 3'b000;
    localparam logic [2:0] OpShl   = 3'b001;
    localparam logic [2:0] OpShr   = 3'b010;
    localparam logic [2:0] OpRol   = 3'b011;
    localparam logic [2:0] OpRor   = 3'b100;
    localparam logic [2:0] OpClear = 3'b101;

    localparam logic [1:0] ModeShift  = 2'b00;
    localparam logic [1:0] ModeRotate = 2'b01;
    localparam logic [1:0] ModeLoad   = 2'b10;
    localparam logic [1:0] ModeClear  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StSettle, StDone} state_e;

    state_e             r_state;
    logic [1:0]         r_modo;
    logic               r_dir;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_data_sh;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_illegal;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_out_bits;
    logic               r_done;
    logic               r_err;

    logic [1:0]         w_modo;
    logic               w_dir;
    logic               w_illegal;
    logic [CNT_W-1:0]   w_eff_cnt;

    // Decode the incoming op into register mode, direction and effective cycle count.
    always_comb begin
        w_modo    = ModeShift;
        w_dir     = 1'b0;
        w_illegal = 1'b0;
        w_eff_cnt = i_cmd_count;
        case (i_cmd_op)
            OpLoad: begin
                w_modo    = ModeLoad;
                w_eff_cnt = CNT_W'(1);
            end
            OpShl: begin
                w_modo = ModeShift;
            end
            OpShr: begin
                w_modo = ModeShift;
                w_dir  = 1'b1;
            end
            OpRol: begin
                w_modo = ModeRotate;
            end
            OpRor: begin
                w_modo = ModeRotate;
                w_dir  = 1'b1;
            end
            OpClear: begin
                w_modo    = ModeClear;
                w_eff_cnt = CNT_W'(1);
            end
            default: begin
                w_illegal = 1'b1;
                w_eff_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_modo      <= ModeShift;
            r_dir       <= 1'b0;
            r_d         <= '0;
            r_data_sh   <= '0;
            r_remaining <= '0;
            r_illegal   <= 1'b0;
            r_result    <= '0;
            r_out_bits  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_modo      <= w_modo;
                        r_dir       <= w_dir;
                        r_d         <= i_cmd_data;
                        r_data_sh   <= i_cmd_data;
                        r_illegal   <= w_illegal;
                        r_remaining <= w_eff_cnt;
                        r_out_bits  <= '0;
                        r_state     <= (w_eff_cnt == '0) ? StSettle : StRun;
                    end
                end
                StRun: begin
                    // A stalled cycle freezes everything so the register sees no update.
                    if (i_enb) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_data_sh   <= {r_data_sh[0], r_data_sh[WIDTH-1:1]};
                        r_out_bits  <= {r_out_bits[WIDTH-2:0], i_s_out};
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    r_result <= i_q;
                    r_err    <= r_illegal;
                    r_done   <= 1'b1;
                    r_state  <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Reset is folded in so ready and the register enable drop without waiting for a clock.
    assign o_cmd_ready = (r_state == StIdle) && !i_reset;
    assign o_reg_enb   = (r_state == StRun) && i_enb && !i_reset;
    assign o_modo      = r_modo;
    assign o_dir       = r_dir;
    assign o_s_in      = r_data_sh[0];
    assign o_d         = r_d;
    assign o_result    = r_result;
    assign o_out_bits  = r_out_bits;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Bench for shiftreg_sequencer: a behavioural shift register closes the loop, directed commands
// push hand-computed results to a queue, and a monitor checks each DONE against it.
`timescale 1ns/1ps
module tb_shiftreg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_count;
    logic       reg_enb;
    logic [1:0] modo;
    logic       dir;
    logic       s_in;
    logic [3:0] d;
    logic [3:0] q = 4'b0000;
    logic       s_out;
    logic [3:0] result;
    logic [3:0] out_bits;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int enb_cnt = 0;

    typedef struct {
        logic [3:0] res;
        logic [3:0] outb;
        logic       err;
        int         lat;
        int         enbn;
        int         t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    shiftreg_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enb       (enb),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_data  (cmd_data),
        .i_cmd_count (cmd_count),
        .o_reg_enb   (reg_enb),
        .o_modo      (modo),
        .o_dir       (dir),
        .o_s_in      (s_in),
        .o_d         (d),
        .i_q         (q),
        .i_s_out     (s_out),
        .o_result    (result),
        .o_out_bits  (out_bits),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External 4-bit enhanced shift register.
    assign s_out = dir ? q[0] : q[3];
    always @(posedge clk) begin
        if (reg_enb) begin
            case (modo)
                2'b00: q <= dir ? {s_in, q[3:1]} : {q[2:0], s_in};
                2'b01: q <= dir ? {q[0], q[3:1]} : {q[2:0], q[3]};
                2'b10: q <= d;
                default: q <= 4'b0000;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            enb_cnt = 0;
        end else begin
            if (reg_enb) enb_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending command");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", 32'(result), 32'(mon_e.res));
                    check("out_bits", 32'(out_bits), 32'(mon_e.outb));
                    check("err", 32'(err), 32'(mon_e.err));
                    check("latency", 32'((cyc + 1) - mon_e.t0), 32'(mon_e.lat));
                    check("reg_enb_cycles", 32'(enb_cnt), 32'(mon_e.enbn));
                end
                enb_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [3:0] cnt,
                         input logic [3:0] res, input logic [3:0] outb, input logic e_err,
                         input int lat, input int enbn, input int stall_at, input int stall_len,
                         input bit push);
        exp_t e;
        int   i;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        for (i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        e.res  = res;
        e.outb = outb;
        e.err  = e_err;
        e.lat  = lat;
        e.enbn = enbn;
        e.t0   = cyc;
        if (push) exp_q.push_back(e);
        if (stall_len > 0) begin
            repeat (stall_at) @(posedge clk);
            #1;
            enb       = 1'b0;
            cmd_valid = 1'b1;
            cmd_op    = 3'b101;
            repeat (stall_len) begin
                check("ready_in_run", 32'(cmd_ready), 32'(0));
                @(posedge clk);
                #1;
            end
            enb       = 1'b1;
            cmd_valid = 1'b0;
        end
        if (push) begin
            for (i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
            if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done expected done within 100 cycles");
                exp_q.delete();
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        enb       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 4'b0000;
        cmd_count = 4'b0000;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'(0));
        check("rst_reg_enb", 32'(reg_enb), 32'(0));
        check("rst_modo_dir_sin", 32'({modo, dir, s_in}), 32'(0));
        check("rst_d", 32'(d), 32'(0));
        check("rst_result_out", 32'({result, out_bits}), 32'(0));
        check("rst_done_err", 32'({done, err}), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_release", 32'(cmd_ready), 32'(1));

        //     op      data     cnt      res      outb   err lat enb stall   push
        issue(3'b000, 4'b1010, 4'd0, 4'b1010, 4'b0000, 0, 3, 1, 0, 0, 1);
        issue(3'b000, 4'b0000, 4'd7, 4'b0000, 4'b0001, 0, 3, 1, 0, 0, 1);
        issue(3'b001, 4'b0011, 4'd2, 4'b0011, 4'b0000, 0, 4, 2, 0, 0, 1);
        issue(3'b000, 4'b1010, 4'd0, 4'b1010, 4'b0000, 0, 3, 1, 0, 0, 1);
        issue(3'b011, 4'b0000, 4'd1, 4'b0101, 4'b0001, 0, 3, 1, 0, 0, 1);
        issue(3'b000, 4'b1010, 4'd0, 4'b1010, 4'b0000, 0, 3, 1, 0, 0, 1);
        issue(3'b100, 4'b0000, 4'd1, 4'b0101, 4'b0000, 0, 3, 1, 0, 0, 1);
        issue(3'b000, 4'b1010, 4'd0, 4'b1010, 4'b0000, 0, 3, 1, 0, 0, 1);
        issue(3'b011, 4'b0000, 4'd4, 4'b1010, 4'b1010, 0, 6, 4, 0, 0, 1);
        issue(3'b000, 4'b1111, 4'd0, 4'b1111, 4'b0001, 0, 3, 1, 0, 0, 1);
        issue(3'b010, 4'b0000, 4'd4, 4'b0000, 4'b1111, 0, 6, 4, 0, 0, 1);
        issue(3'b000, 4'b0000, 4'd0, 4'b0000, 4'b0000, 0, 3, 1, 0, 0, 1);
        issue(3'b001, 4'b0101, 4'd3, 4'b0101, 4'b0000, 0, 7, 3, 1, 2, 1);
        issue(3'b101, 4'b1111, 4'd9, 4'b0000, 4'b0000, 0, 3, 1, 0, 0, 1);
        issue(3'b110, 4'b1111, 4'd5, 4'b0000, 4'b0000, 1, 2, 0, 0, 0, 1);
        issue(3'b001, 4'b1111, 4'd0, 4'b0000, 4'b0000, 0, 2, 0, 0, 0, 1);
        issue(3'b000, 4'b0110, 4'd0, 4'b0110, 4'b0000, 0, 3, 1, 0, 0, 1);

        // Reset in the middle of a long rotate: no DONE may follow.
        issue(3'b011, 4'b0000, 4'd8, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reg_enb_mid_run", 32'(reg_enb), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("reset_reg_enb_drop", 32'(reg_enb), 32'(0));
        check("reset_ready_low", 32'(cmd_ready), 32'(0));
        repeat (2) @(negedge clk);
        check("reset_result_out", 32'({result, out_bits}), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_after_mid_reset", 32'(cmd_ready), 32'(1));
        repeat (12) @(negedge clk);

        issue(3'b000, 4'b1001, 4'd0, 4'b1001, 4'b0000, 0, 3, 1, 0, 0, 1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shiftreg_sequencer.md
# shiftreg_sequencer

Command-driven sequencer that sits directly upstream of the 4-bit enhanced shift register. It accepts one operation at a time over a valid/ready handshake, drives the register's ENB/MODO/DIR/S_IN/D inputs for the required number of cycles, and reports the result. The result is the register's final Q, plus the serial bits that left the register on S_OUT, with a one-cycle DONE pulse. It removes hand-timed MODO sequencing from the design and the testbenches.

## Interface
- WIDTH, 4, register width; must match the shift register.
- CNT_W, 4, width of the shift-count field.

- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENB  in  1  global enable; 0 stalls the sequencer and the register.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  3  000 LOAD, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 CLEAR, 110/111 illegal.
- CMD_DATA  in  WIDTH  LOAD value, or serial-in bit pattern for SHL/SHR.
- CMD_COUNT  in  CNT_W  number of shift/rotate cycles; ignored for LOAD/CLEAR.
- REG_ENB, MODO[1:0], DIR, S_IN, D[WIDTH-1:0]  out  —  drive the shift register inputs of the same names.
- Q  in  WIDTH  register parallel output.
- S_OUT  in  1  register serial output.
- RESULT  out  WIDTH  Q captured at completion.
- OUT_BITS  out  WIDTH  last WIDTH S_OUT samples, newest in bit 0.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  qualifies DONE; 1 = illegal op.

## Operation
- Register modes: MODO 00 shift, 01 rotate, 10 parallel load, 11 clear.
  - DIR=0 is left: Q ← {Q[W-2:0], S_IN}.
  - DIR=1 is right: Q ← {S_IN, Q[W-1:1]}.
  - The register has no hold mode, so REG_ENB=0 is the only idle state.
- Op mapping (MODO, DIR):
  - LOAD: 10, x.
  - SHL: 00, 0.
  - SHR: 00, 1.
  - ROL: 01, 0.
  - ROR: 01, 1.
  - CLEAR: 11, x.
- D is driven with the latched CMD_DATA throughout.
- FSM states IDLE, RUN, SETTLE, DONE.
  - **IDLE**
    - CMD_READY=1 (forced 0 while RESET=1); REG_ENB=0.
    - On CMD_VALID&CMD_READY at an edge: latch op, data, count; clear OUT_BITS.
    - Effective count is 1 for LOAD/CLEAR and 0 for illegal ops.
    - Effective count 0 → SETTLE; otherwise → RUN.
  - **RUN**
    - REG_ENB=ENB.
    - S_IN = data_sh[0]. data_sh rotates right on each enabled edge, so cycle k uses CMD_DATA[k mod WIDTH].
    - Each edge with ENB=1: remaining decrements, and OUT_BITS ← {OUT_BITS[W-2:0], S_OUT}.
    - remaining==1 with ENB=1 → SETTLE.
    - ENB=0 freezes remaining, data_sh and OUT_BITS.
  - **SETTLE**
    - REG_ENB=0.
    - At the edge leaving SETTLE: RESULT ← Q; ERR ← illegal op. → DONE.
  - **DONE**
    - DONE=1 for exactly one cycle; CMD_READY=0. → IDLE.
- CMD_VALID is ignored outside IDLE. The requester must hold the command and its fields until CMD_READY.
- RESULT, OUT_BITS and ERR hold until the next DONE. OUT_BITS clears at command accept.

## Timing
- Reset values:
  - State IDLE.
  - REG_ENB=0, MODO=00, DIR=0, S_IN=0, D=0.
  - RESULT=0, OUT_BITS=0, DONE=0, ERR=0.
  - CMD_READY=0 while RESET=1 and 1 in the first cycle after release.
- Latency with ENB held 1: accept edge t0; DONE high in cycle t0+N+2, where N is the effective count.
  - LOAD/CLEAR: DONE in cycle t0+3.
  - Count 0 or illegal op: DONE in cycle t0+2.
- Throughput: the next command can be accepted on the edge ending the cycle after DONE.
- Each cycle of ENB=0 during RUN adds one cycle of latency. No register update occurs in stalled cycles.
- RESET mid-operation: immediate return to IDLE. REG_ENB drops to 0 asynchronously and no DONE is issued. Register contents are undefined afterwards.
- Count wrap: CMD_COUNT max = 2^CNT_W-1 cycles. No modulo-WIDTH reduction.

## Test plan
- Reset, then LOAD D=1010 → MODO=10 for 1 cycle, DONE at t0+3, RESULT=1010, ERR=0.
- LOAD 0000, then SHL count 2, data 0011 → RESULT=0011; REG_ENB high for exactly 2 cycles.
- LOAD 1010, then ROL count 1 → RESULT=0101; ROR count 1 from 1010 → RESULT=0101; ROL count 4 → RESULT=1010.
- LOAD 1111, then SHR count 4, data 0000 → RESULT=0000; OUT_BITS=1111 (register S_OUT=Q[0] for right shift).
- SHL count 3 with ENB pulled low for 2 cycles mid-RUN → DONE at t0+7; result identical to the unstalled run. CMD_VALID asserted during RUN is not accepted.
- Illegal op 110 → no REG_ENB activity, DONE at t0+2 with ERR=1. RESET asserted mid-RUN of ROL count 8 → REG_ENB=0 immediately, no DONE, CMD_READY=1 after release.
